// File: rtl/seven_segment_mux_driver_if.sv
// Count hand-off between the frequency counter stage and the display driver.
interface seven_segment_mux_driver_if #(
  parameter int BIN_WIDTH = 8
);
  logic [BIN_WIDTH-1:0] value_i;
  logic                 value_valid_i;
  logic                 busy_o;
  logic                 overflow_o;

  modport master (output value_i, value_valid_i, input busy_o, overflow_o);
  modport slave  (input value_i, value_valid_i, output busy_o, overflow_o);
endinterface

// File: rtl/seven_segment_mux_driver.sv
// Binary-to-BCD display driver: sequential double-dabble with overflow
// saturation, followed by a time-multiplexed common-cathode digit scan.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a new count (strobe or held pending value)
// ST_CONVERT | one double-dabble step per cycle, BIN_WIDTH cycles
// ST_LOAD    | publish BCD (or all-9s) to the display, chain pending value
module seven_segment_mux_driver #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 8,
  parameter int MUX_CYCLES = 1024
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  seven_segment_mux_driver_if.slave cnt,
  input  logic                      blank_i,
  output logic [6:0]                segments_o,
  output logic [NUM_DIGITS-1:0]     digit_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(MUX_CYCLES);
  localparam int BIT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_LOAD} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] shift_bin;
  logic [BCD_W-1:0]     bcd;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 ovf_flag;
  logic                 pend_valid;
  logic [BIN_WIDTH-1:0] pend_val;
  logic [BCD_W-1:0]     display;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_next;
  logic [BIN_WIDTH-1:0] bin_next;
  logic                 start_req;
  logic [BIN_WIDTH-1:0] start_val;
  logic                 start_ovf;

  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  upper_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // One double-dabble step; upper BCD bits beyond the display width are dropped,
  // which only matters for values that saturate anyway.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_next, bin_next} = {bcd_adj, shift_bin} << 1;
  end

  // A fresh strobe always beats the pending register (newest value wins).
  always_comb begin
    start_req = cnt.value_valid_i | pend_valid;
    start_val = cnt.value_valid_i ? cnt.value_i : pend_val;
    start_ovf = {{(32-BIN_WIDTH){1'b0}}, start_val} > MAX_VAL;
  end

  // Conversion FSM with pending capture and registered busy/overflow.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= ST_IDLE;
      shift_bin      <= '0;
      bcd            <= '0;
      bit_cnt        <= '0;
      ovf_flag       <= 1'b0;
      pend_valid     <= 1'b0;
      pend_val       <= '0;
      display        <= '0;
      cnt.busy_o     <= 1'b0;
      cnt.overflow_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            shift_bin  <= start_val;
            bcd        <= '0;
            bit_cnt    <= BIT_W'(BIN_WIDTH);
            ovf_flag   <= start_ovf;
            pend_valid <= 1'b0;
            cnt.busy_o <= 1'b1;
            state      <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (cnt.value_valid_i) begin
            pend_valid <= 1'b1;
            pend_val   <= cnt.value_i;
          end
          shift_bin <= bin_next;
          bcd       <= bcd_next;
          bit_cnt   <= bit_cnt - 1'b1;
          if (bit_cnt == BIT_W'(1)) state <= ST_LOAD;
        end
        ST_LOAD: begin
          display        <= ovf_flag ? {NUM_DIGITS{4'h9}} : bcd;
          cnt.overflow_o <= ovf_flag;
          pend_valid     <= 1'b0;
          if (start_req) begin
            shift_bin <= start_val;
            bcd       <= '0;
            bit_cnt   <= BIT_W'(BIN_WIDTH);
            ovf_flag  <= start_ovf;
            state     <= ST_CONVERT;
          end else begin
            cnt.busy_o <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it are zero.
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (display[4*i +: 4] == 4'd0);
      blank_mask[i] = blank_i & upper_zero;
    end
  end

  // Digit scan: refresh timer, digit index and registered display outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      segments_o  <= 7'h00;
      digit_o     <= '0;
    end else begin
      if (refresh_cnt == CNT_W'(MUX_CYCLES - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      digit_o    <= NUM_DIGITS'(1) << digit_idx;
      segments_o <= blank_mask[digit_idx] ? 7'h00 : seg_decode(display[{digit_idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Randomized self-checking bench for the 7-segment mux driver.
module tb_seven_segment_mux_driver;
  localparam int ND = 2;
  localparam int BW = 8;
  localparam int MC = 4;

  logic          clk;
  logic          rst;
  logic          blank;
  logic [6:0]    segments;
  logic [ND-1:0] digit;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segment_mux_driver_if #(.BIN_WIDTH(BW)) cnt_if ();

  seven_segment_mux_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .MUX_CYCLES(MC)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cnt        (cnt_if),
    .blank_i    (blank),
    .segments_o (segments),
    .digit_o    (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what a digit position should show for a given accepted value.
  function automatic logic [6:0] exp_seg(input int v, input int d, input bit blk);
    int p;
    int lim;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * 10;
    if (v >= lim) return seg_tab[9];
    if (blk && d > 0 && v < p) return 7'h00;
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic strobe(input int v);
    cnt_if.value_i = BW'(v);
    cnt_if.value_valid_i = 1'b1;
    @(negedge clk);
    cnt_if.value_valid_i = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (cnt_if.busy_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_digit(input int d, output logic [6:0] seg, output bit ok);
    ok = 1'b0;
    seg = 7'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (digit === ND'(1 << d)) begin
        seg = segments;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (digit !== '0 || segments !== 7'h00 || cnt_if.busy_o !== 1'b0 || cnt_if.overflow_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: digit=%h seg=%h busy=%b ovf=%b required 0/00/0/0",
               digit, segments, cnt_if.busy_o, cnt_if.overflow_o);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (digit !== ND'(1 << (((k - 1) / MC) % ND)) || segments !== 7'h3F) begin
        n_bad++;
        $display("FAIL reset_scan k=%0d: digit=%h seg=%h required digit=%h seg=3f",
                 k, digit, segments, ND'(1 << (((k - 1) / MC) % ND)));
      end
    end
  endtask

  task automatic test_value(input int v, input bit blk, input string tag);
    int n;
    logic [6:0] s;
    bit ok;
    blank = blk;
    strobe(v);
    count_busy(n);
    n_cmp++;
    if (n !== BW + 1) begin
      n_bad++;
      $display("FAIL %s busy_len v=%0d: %0d cycles required %0d", tag, v, n, BW + 1);
    end
    n_cmp++;
    if (cnt_if.overflow_o !== (v > 99)) begin
      n_bad++;
      $display("FAIL %s overflow v=%0d: %b required %b", tag, v, cnt_if.overflow_o, v > 99);
    end
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s, ok);
      n_cmp++;
      if (!ok || s !== exp_seg(v, d, blk)) begin
        n_bad++;
        $display("FAIL %s digit%0d v=%0d blank=%b: seg=%h found=%b required %h",
                 tag, d, v, blk, s, ok, exp_seg(v, d, blk));
      end
    end
  endtask

  task automatic test_blank_live;
    logic [6:0] s;
    bit ok;
    test_value(7, 1'b1, "blank_on");
    blank = 1'b0;
    read_digit(1, s, ok);
    n_cmp++;
    if (!ok || s !== 7'h3F) begin
      n_bad++;
      $display("FAIL blank_off digit1: seg=%h found=%b required 3f", s, ok);
    end
  endtask

  task automatic test_back_to_back;
    int hi;
    int d;
    blank = 1'b0;
    hi = 0;
    strobe(12);
    for (int t = 0; t < 18; t++) begin
      if (cnt_if.busy_o === 1'b1) hi++;
      if (t >= 11) begin
        d = (digit === 2'b10) ? 1 : 0;
        n_cmp++;
        if (segments !== exp_seg(12, d, 1'b0)) begin
          n_bad++;
          $display("FAIL b2b_first_shown t=%0d digit%0d: seg=%h required %h", t, d, segments, exp_seg(12, d, 1'b0));
        end
      end
      if (t == 2) begin cnt_if.value_i = 8'd34; cnt_if.value_valid_i = 1'b1; end
      if (t == 5) begin cnt_if.value_i = 8'd56; cnt_if.value_valid_i = 1'b1; end
      if (t == 3 || t == 6) cnt_if.value_valid_i = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (hi !== 18 || cnt_if.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy: high=%0d end_busy=%b required 18/0", hi, cnt_if.busy_o);
    end
    for (int k = 0; k < ND; k++) begin
      logic [6:0] s;
      bit ok;
      read_digit(k, s, ok);
      n_cmp++;
      if (!ok || s !== exp_seg(56, k, 1'b0)) begin
        n_bad++;
        $display("FAIL b2b_final digit%0d: seg=%h found=%b required %h", k, s, ok, exp_seg(56, k, 1'b0));
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      test_value(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [6:0] s;
    bit ok;
    test_value(150, 1'b0, "pre_reset");
    strobe(200);
    @(negedge clk);
    strobe(77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cnt_if.busy_o !== 1'b0 || cnt_if.overflow_o !== 1'b0 || digit !== '0 || segments !== 7'h00) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: busy=%b ovf=%b digit=%h seg=%h required 0/0/0/00",
               cnt_if.busy_o, cnt_if.overflow_o, digit, segments);
    end
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cnt_if.busy_o !== 1'b0) n++;
    end
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_pending: busy seen %0d cycles required 0", n);
    end
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s, ok);
      n_cmp++;
      if (!ok || s !== 7'h3F) begin
        n_bad++;
        $display("FAIL reset_mid_display digit%0d: seg=%h found=%b required 3f", d, s, ok);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    blank = 1'b0;
    cnt_if.value_i = '0;
    cnt_if.value_valid_i = 1'b0;
    @(negedge clk);
    test_reset;
    test_value(42, 1'b0, "value42");
    test_value(150, 1'b0, "ovf150");
    test_value(99, 1'b0, "max99");
    test_value(0, 1'b1, "zero_blank");
    test_blank_live;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
